// File: rtl/sync_mem_ctrl.sv
// sync_mem_ctrl: single-clock memory for the 6502 system bus.
// Port A is a read/write CPU port, port B a read-only video/debug port.
// Both ports have registered one-cycle reads. Included: a write-protected window,
// out-of-range detection and an optional clear engine that runs after reset.
module sync_mem_ctrl #(
  parameter int unsigned              DATA_WIDTH     = 8,
  parameter int unsigned              ADDR_WIDTH     = 15,
  parameter int unsigned              SIZE           = 4096,
  parameter string                    MEM_INIT_FILE  = "",
  parameter bit                       RESET_VECTOR   = 1'b0,
  parameter int unsigned              WP_BASE        = 'h1000,
  parameter int unsigned              WP_LIMIT       = 'h0FFF,
  parameter bit                       CLEAR_ON_RESET = 1'b0,
  parameter logic [DATA_WIDTH-1:0]    CLEAR_VALUE    = '0,
  parameter logic [DATA_WIDTH-1:0]    OOR_VALUE      = DATA_WIDTH'('hFF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_rvalid,
  output logic                  a_busy,
  input  logic                  b_req,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_rvalid,
  output logic                  wp_err,
  output logic                  oor_err
);

  localparam int unsigned           IW       = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [ADDR_WIDTH:0]   SIZE_X   = (ADDR_WIDTH + 1)'(SIZE);
  localparam logic [ADDR_WIDTH-1:0] WP_B     = ADDR_WIDTH'(WP_BASE);
  localparam logic [ADDR_WIDTH-1:0] WP_L     = ADDR_WIDTH'(WP_LIMIT);
  localparam logic [IW-1:0]         CNT_LAST = IW'(SIZE - 1);
  localparam int unsigned           RV_LO    = 'h1FFC;
  localparam int unsigned           RV_HI    = 'h1FFD;

  typedef enum logic {CLEAR, READY} state_t;

  logic [DATA_WIDTH-1:0] mem [SIZE];

  state_t          state, state_next;
  logic [IW-1:0]   cnt;
  logic            a_acc, b_acc, a_oor, b_oor, a_wp, cnt_wp;
  logic [IW-1:0]   a_idx, b_idx;
  logic            mem_we;
  logic [IW-1:0]   mem_widx;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Elaboration-time image: zero fill, then the reset vector.
  function automatic bit load_image();
    mem = '{default: '0};
    if (RESET_VECTOR && (SIZE > RV_HI)) begin
      mem[IW'(RV_LO)] = DATA_WIDTH'('h00);
      mem[IW'(RV_HI)] = DATA_WIDTH'('h80);
    end
    return 1'b1;
  endfunction

  logic unused_image_loaded = load_image();

  assign a_acc  = a_req & ~reset & (state == READY);
  assign b_acc  = b_req & ~reset & (state == READY);
  assign a_oor  = {1'b0, a_addr} >= SIZE_X;
  assign b_oor  = {1'b0, b_addr} >= SIZE_X;
  assign a_wp   = (a_addr >= WP_B) && (a_addr <= WP_L);
  assign cnt_wp = (ADDR_WIDTH'(cnt) >= WP_B) && (ADDR_WIDTH'(cnt) <= WP_L);
  assign a_idx  = a_addr[IW-1:0];
  assign b_idx  = b_addr[IW-1:0];

  // State register and clear counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? CLEAR : READY;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  // Next state, busy flag and the single memory write port (clear engine or port A).
  always_comb begin
    state_next = state;
    a_busy     = 1'b0;
    mem_we     = 1'b0;
    mem_widx   = a_idx;
    mem_wdata  = a_wdata;
    case (state)
      CLEAR: begin
        a_busy = 1'b1;
        if (!reset && !cnt_wp) begin
          mem_we    = 1'b1;
          mem_widx  = cnt;
          mem_wdata = CLEAR_VALUE;
        end
        if (cnt == CNT_LAST) state_next = READY;
      end
      READY: begin
        if (a_acc && a_we && !a_oor && !a_wp) mem_we = 1'b1;
      end
      default: state_next = READY;
    endcase
  end

  // Memory array write; non-blocking so a same-cycle port B read sees old data.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  // Registered read data, valid strobes and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdata  <= '0;
      b_rdata  <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      wp_err   <= 1'b0;
      oor_err  <= 1'b0;
    end else begin
      a_rvalid <= a_acc & ~a_we;
      b_rvalid <= b_acc;
      if (a_acc && !a_we) a_rdata <= a_oor ? OOR_VALUE : mem[a_idx];
      if (b_acc)          b_rdata <= b_oor ? OOR_VALUE : mem[b_idx];
      wp_err  <= a_acc & a_we & ~a_oor & a_wp;
      oor_err <= (a_acc & a_oor) | (b_acc & b_oor);
    end
  end

endmodule

// File: tb/tb_sync_mem_ctrl.sv
// Directed testbench for sync_mem_ctrl: a main instance (8K words, reset vector,
// protected window 'h1000-'h1FFF) and a small 16-word instance with the clear engine.
module tb_sync_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Main instance signals
    logic        rst_m = 1'b1;
    logic        m_a_req = 1'b0, m_a_we = 1'b0, m_b_req = 1'b0;
    logic [14:0] m_a_addr = '0, m_b_addr = '0;
    logic [7:0]  m_a_wdata = '0;
    logic [7:0]  m_a_rdata, m_b_rdata;
    logic        m_a_rvalid, m_b_rvalid, m_busy, m_wp_err, m_oor_err;

    // Clear-engine instance signals
    logic        rst_c = 1'b1;
    logic        c_a_req = 1'b0, c_a_we = 1'b0, c_b_req = 1'b0;
    logic [14:0] c_a_addr = '0, c_b_addr = '0;
    logic [7:0]  c_a_wdata = '0;
    logic [7:0]  c_a_rdata, c_b_rdata;
    logic        c_a_rvalid, c_b_rvalid, c_busy, c_wp_err, c_oor_err;

    sync_mem_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(15), .SIZE(8192), .RESET_VECTOR(1'b1),
        .WP_BASE('h1000), .WP_LIMIT('h1FFF)
    ) u_main (
        .clk(clk), .reset(rst_m),
        .a_req(m_a_req), .a_we(m_a_we), .a_addr(m_a_addr), .a_wdata(m_a_wdata),
        .a_rdata(m_a_rdata), .a_rvalid(m_a_rvalid), .a_busy(m_busy),
        .b_req(m_b_req), .b_addr(m_b_addr), .b_rdata(m_b_rdata), .b_rvalid(m_b_rvalid),
        .wp_err(m_wp_err), .oor_err(m_oor_err)
    );

    sync_mem_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(15), .SIZE(16), .CLEAR_ON_RESET(1'b1),
        .CLEAR_VALUE(8'h00)
    ) u_clr (
        .clk(clk), .reset(rst_c),
        .a_req(c_a_req), .a_we(c_a_we), .a_addr(c_a_addr), .a_wdata(c_a_wdata),
        .a_rdata(c_a_rdata), .a_rvalid(c_a_rvalid), .a_busy(c_busy),
        .b_req(c_b_req), .b_addr(c_b_addr), .b_rdata(c_b_rdata), .b_rvalid(c_b_rvalid),
        .wp_err(c_wp_err), .oor_err(c_oor_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hold requests on both ports while busy; none may produce a response.
    task automatic wait_clear(input string tag);
        int n = 0;
        c_a_req = 1'b1; c_a_we = 1'b0; c_a_addr = 15'd3;
        c_b_req = 1'b1; c_b_addr = 15'd3;
        while (c_busy && n < 100) begin
            n++;
            tick();
            check({tag, "_a_rvalid"}, c_a_rvalid, 0);
            check({tag, "_b_rvalid"}, c_b_rvalid, 0);
        end
        c_a_req = 1'b0; c_b_req = 1'b0;
        check({tag, "_busy_cycles"}, n, 16);
    endtask

    task automatic c_write(input int addr, input logic [7:0] data);
        c_a_req = 1'b1; c_a_we = 1'b1; c_a_addr = 15'(addr); c_a_wdata = data;
        tick();
        c_a_req = 1'b0; c_a_we = 1'b0;
    endtask

    task automatic c_read_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            c_a_req = 1'b1; c_a_we = 1'b0; c_a_addr = 15'(i);
            tick();
            check({tag, "_rvalid"}, c_a_rvalid, 1);
            check({tag, "_data"}, c_a_rdata, 8'h00);
        end
        c_a_req = 1'b0;
    endtask

    initial begin
        // ---------------- main instance ----------------
        tick(); tick();
        check("rst_a_rdata", m_a_rdata, 0);
        check("rst_a_rvalid", m_a_rvalid, 0);
        check("rst_b_rvalid", m_b_rvalid, 0);
        check("rst_wp_err", m_wp_err, 0);
        check("rst_oor_err", m_oor_err, 0);
        check("rst_busy", m_busy, 0);
        rst_m = 1'b0;

        // Reset vector, back-to-back reads, hold after last read
        m_a_req = 1'b1; m_a_we = 1'b0; m_a_addr = 15'h1FFC;
        tick();
        check("rv_lo_valid", m_a_rvalid, 1);
        check("rv_lo_data", m_a_rdata, 8'h00);
        m_a_addr = 15'h1FFD;
        tick();
        check("rv_hi_valid", m_a_rvalid, 1);
        check("rv_hi_data", m_a_rdata, 8'h80);
        m_a_req = 1'b0;
        tick();
        check("idle_rvalid", m_a_rvalid, 0);
        check("hold_rdata", m_a_rdata, 8'h80);

        // Write with same-cycle B read (old data), then read-after-write on both ports
        m_a_req = 1'b1; m_a_we = 1'b1; m_a_addr = 15'h0010; m_a_wdata = 8'h5A;
        m_b_req = 1'b1; m_b_addr = 15'h0010;
        tick();
        check("wr_no_rvalid", m_a_rvalid, 0);
        check("coll_b_valid", m_b_rvalid, 1);
        check("coll_b_old", m_b_rdata, 8'h00);
        m_a_we = 1'b0;
        tick();
        check("raw_a_data", m_a_rdata, 8'h5A);
        check("raw_b_data", m_b_rdata, 8'h5A);
        m_b_req = 1'b0;

        // Protected write is dropped and pulses wp_err
        m_a_we = 1'b1; m_a_addr = 15'h1800; m_a_wdata = 8'h33;
        tick();
        check("wp_err_pulse", m_wp_err, 1);
        check("wp_no_oor", m_oor_err, 0);
        m_a_we = 1'b0;
        tick();
        check("wp_err_clear", m_wp_err, 0);
        check("wp_readback", m_a_rdata, 8'h00);
        // Last in-range word is also protected
        m_a_we = 1'b1; m_a_addr = 15'h1FFF; m_a_wdata = 8'h44;
        tick();
        check("wp_edge_hi", m_wp_err, 1);
        // Word just below the window is writable
        m_a_addr = 15'h0FFF; m_a_wdata = 8'h11;
        tick();
        check("wp_edge_lo", m_wp_err, 0);
        m_a_we = 1'b0;
        tick();
        check("below_wp_data", m_a_rdata, 8'h11);

        // Out-of-range read and write
        m_a_addr = 15'h2000;
        tick();
        check("oor_rd_valid", m_a_rvalid, 1);
        check("oor_rd_data", m_a_rdata, 8'hFF);
        check("oor_rd_err", m_oor_err, 1);
        m_a_we = 1'b1; m_a_wdata = 8'h77;
        tick();
        check("oor_wr_err", m_oor_err, 1);
        check("oor_wr_no_wp", m_wp_err, 0);
        m_a_we = 1'b0; m_a_addr = 15'h0000;
        tick();
        check("oor_no_alias", m_a_rdata, 8'h00);
        check("oor_err_clear", m_oor_err, 0);
        m_a_req = 1'b0;
        m_b_req = 1'b1; m_b_addr = 15'h7FFF;
        tick();
        check("oor_b_data", m_b_rdata, 8'hFF);
        check("oor_b_err", m_oor_err, 1);
        m_b_req = 1'b0;

        // ---------------- clear-engine instance ----------------
        check("clr_busy_in_reset", c_busy, 1);
        rst_c = 1'b0;
        wait_clear("clr0");

        for (int i = 0; i < 16; i++) c_write(i, 8'(i + 1));
        c_a_req = 1'b1; c_a_addr = 15'd7;
        tick();
        check("preload_data", c_a_rdata, 8'h08);
        c_a_addr = 15'd16;
        tick();
        check("c_oor_data", c_a_rdata, 8'hFF);
        check("c_oor_err", c_oor_err, 1);
        c_a_addr = 15'd15;
        tick();
        check("c_last_data", c_a_rdata, 8'h10);
        check("c_last_no_oor", c_oor_err, 0);
        c_a_req = 1'b0;

        rst_c = 1'b1;
        tick();
        check("clr1_busy_reset", c_busy, 1);
        rst_c = 1'b0;
        wait_clear("clr1");
        c_read_all_zero("clr1_read");

        // Reset during the clear at cnt=7 restarts the full sweep
        for (int i = 0; i < 16; i++) c_write(i, 8'(8'hA0 + i));
        rst_c = 1'b1;
        tick();
        rst_c = 1'b0;
        repeat (7) tick();
        check("mid_busy_before", c_busy, 1);
        rst_c = 1'b1;
        tick();
        check("mid_busy_reset", c_busy, 1);
        rst_c = 1'b0;
        wait_clear("clr2");
        c_read_all_zero("clr2_read");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
